// File: rtl/vpu_dst_port.sv
// vpu_dst_port -- destination-side SRAM write port of the VPU.
//
// Packs R = SRAM_DATA_WIDTH/RESULT_WIDTH lane results into one SRAM word.
// Packed words go into a small FIFO. The FIFO drains to one SRAM write port
// over a req/ack handshake, at consecutive beat addresses.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start_i             one-cycle command pulse (honoured only in IDLE)
//   base_addr_i, len_i  first beat address / beat count, sampled with start_i
//   busy_o, done_o      command in progress / one-cycle completion pulse
//   result_valid_i/_data_i/_ready_o  lane result stream (valid/ready)
//   req_o, ack_i        SRAM write handshake; beat moves on req_o && ack_i
//   addr_o, wdata_o     beat address and data, stable while req_o && !ack_i
//   wlast_o             marks the final beat of the command
module vpu_dst_port #(
    parameter int SRAM_DATA_WIDTH = 512,
    parameter int RESULT_WIDTH    = 128,
    parameter int ADDR_WIDTH      = 16,
    parameter int LEN_WIDTH       = 8,
    parameter int BUF_DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [ADDR_WIDTH-1:0]      base_addr_i,
    input  logic [LEN_WIDTH-1:0]       len_i,
    output logic                       busy_o,
    output logic                       done_o,
    input  logic                       result_valid_i,
    input  logic [RESULT_WIDTH-1:0]    result_data_i,
    output logic                       result_ready_o,
    output logic                       req_o,
    input  logic                       ack_i,
    output logic [ADDR_WIDTH-1:0]      addr_o,
    output logic [SRAM_DATA_WIDTH-1:0] wdata_o,
    output logic                       wlast_o
);
    localparam int R      = SRAM_DATA_WIDTH / RESULT_WIDTH;
    localparam int RSH    = $clog2(R);
    localparam int LANE_W = (R > 1) ? RSH : 1;
    localparam int ACC_W  = LEN_WIDTH + RSH;
    localparam int PTR_W  = $clog2(BUF_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                     r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]      r_base;
    logic [LEN_WIDTH-1:0]       r_len;
    logic [ACC_W-1:0]           r_acc;
    logic [LEN_WIDTH-1:0]       r_wr_cnt;
    logic [LANE_W-1:0]          r_lane;
    logic [SRAM_DATA_WIDTH-1:0] r_pack;
    logic [SRAM_DATA_WIDTH-1:0] r_buf [BUF_DEPTH];
    logic [PTR_W-1:0]           r_rd_ptr, r_wr_ptr;
    logic [CNT_W-1:0]           r_count;

    logic                       w_run, w_start, w_lane_last, w_full, w_empty;
    logic                       w_accept, w_push, w_pop, w_last_beat;
    logic [ACC_W-1:0]           w_total;
    logic [SRAM_DATA_WIDTH-1:0] w_word;

    assign w_run       = (r_state == S_RUN);
    assign w_start     = (r_state == S_IDLE) && start_i;
    assign w_lane_last = (r_lane == LANE_W'(R - 1));
    // Registered count only: a pop in this cycle does not free the slot, so
    // result_ready_o never depends on ack_i.
    assign w_full      = (r_count == CNT_W'(BUF_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_total     = ACC_W'(r_len) << RSH;
    assign w_last_beat = (r_wr_cnt == r_len - LEN_WIDTH'(1));

    // Only the lane-R-1 accept needs a free slot. Earlier lanes just fill
    // the packer register.
    assign result_ready_o = w_run && (r_acc < w_total) && !(w_lane_last && w_full);
    assign w_accept       = result_valid_i && result_ready_o;
    assign w_push         = w_accept && w_lane_last;
    assign w_pop          = req_o && ack_i;

    assign req_o   = w_run && !w_empty;
    assign addr_o  = r_base + ADDR_WIDTH'(r_wr_cnt);
    assign wdata_o = req_o ? r_buf[r_rd_ptr] : '0;
    assign wlast_o = req_o && w_last_beat;
    assign busy_o  = (r_state != S_IDLE);
    assign done_o  = (r_state == S_DONE);

    // Packer view including this cycle's result. It is pushed directly when
    // the result fills the last lane.
    always_comb begin
        w_word = r_pack;
        for (int k = 0; k < R; k++) begin
            if (r_lane == LANE_W'(k))
                w_word[k*RESULT_WIDTH +: RESULT_WIDTH] = result_data_i;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_nxt = (len_i != '0) ? S_RUN : S_DONE;
            S_RUN:   if (w_pop && w_last_beat) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_base   <= '0;
            r_len    <= '0;
            r_acc    <= '0;
            r_wr_cnt <= '0;
            r_lane   <= '0;
            r_pack   <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_base   <= base_addr_i;
                r_len    <= len_i;
                r_acc    <= '0;
                r_wr_cnt <= '0;
                r_lane   <= '0;
                r_pack   <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_accept) begin
                    r_acc  <= r_acc + ACC_W'(1);
                    r_lane <= w_lane_last ? '0 : r_lane + LANE_W'(1);
                    r_pack <= w_word;
                end
                if (w_push) begin
                    r_buf[r_wr_ptr] <= w_word;
                    r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                    r_wr_cnt <= r_wr_cnt + LEN_WIDTH'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vpu_dst_port.sv
module tb_vpu_dst_port;
    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [15:0]  base_addr_i;
    logic [7:0]   len_i;
    logic         busy_o, done_o;
    logic         result_valid_i;
    logic [127:0] result_data_i;
    logic         result_ready_o;
    logic         req_o, ack_i;
    logic [15:0]  addr_o;
    logic [511:0] wdata_o;
    logic         wlast_o;

    vpu_dst_port dut (
        .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
        .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
        .result_valid_i(result_valid_i), .result_data_i(result_data_i),
        .result_ready_o(result_ready_o), .req_o(req_o), .ack_i(ack_i),
        .addr_o(addr_o), .wdata_o(wdata_o), .wlast_o(wlast_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]  addr;
        logic [511:0] data;
        logic         last;
    } beat_t;

    beat_t       sb_q[$];
    logic [15:0] seen_q[$];
    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int last_ack_cyc = 0;
    int g_acc = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk(input int n);
        mk = {32'(n) ^ 32'hD000_0000, 32'(n) ^ 32'hC000_0000,
              32'(n) ^ 32'hB000_0000, 32'(n) ^ 32'hA000_0000};
    endfunction

    // Monitor: scoreboard pop on every transferred beat, plus hold-stability.
    beat_t        e;
    logic         h_hold = 1'b0;
    logic [15:0]  h_addr;
    logic [511:0] h_data;
    logic         h_last;
    always @(negedge clk) begin
        if (rst) begin
            h_hold = 1'b0;
        end else begin
            if (h_hold) begin
                chk("hold_req", 512'(req_o), 512'(1));
                chk("hold_addr", 512'(addr_o), 512'(h_addr));
                chk("hold_data", wdata_o, h_data);
                chk("hold_last", 512'(wlast_o), 512'(h_last));
            end
            h_hold = req_o && !ack_i;
            h_addr = addr_o; h_data = wdata_o; h_last = wlast_o;
            if (req_o && ack_i) begin
                seen_q.push_back(addr_o);
                if (wlast_o) last_ack_cyc = cyc_cnt;
                if (sb_q.size() == 0) begin
                    chk("beat_unexpected", 512'(addr_o), 512'hDEAD);
                end else begin
                    e = sb_q.pop_front();
                    chk("beat_addr", 512'(addr_o), 512'(e.addr));
                    chk("beat_data", wdata_o, e.data);
                    chk("beat_last", 512'(wlast_o), 512'(e.last));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start(input logic [15:0] base, input logic [7:0] len);
        start_i = 1'b1; base_addr_i = base; len_i = len;
        tick();
        start_i = 1'b0;
    endtask

    // Drives nres results; every fourth accepted one completes an expected beat.
    task automatic feed(input logic [15:0] base, input int len, input int nres,
                        input int tag, output int cyc);
        logic [511:0] w;
        logic [15:0]  a;
        beat_t        b;
        int acc;
        acc = 0; cyc = 0; w = '0; g_acc = 0;
        result_valid_i = 1'b1;
        result_data_i  = mk(tag);
        while (acc < nres && cyc < 2000) begin
            @(negedge clk);
            if (result_ready_o) begin
                w[(acc % 4) * 128 +: 128] = result_data_i;
                acc++;
                g_acc = acc;
                if (acc % 4 == 0) begin
                    a = base + 16'(acc / 4 - 1);
                    b.addr = a; b.data = w; b.last = (acc / 4 == len);
                    sb_q.push_back(b);
                    w = '0;
                end
            end
            tick();
            result_data_i = mk(tag + acc);
            cyc++;
        end
        result_valid_i = 1'b0;
        chk("feed_accepts", 512'(acc), 512'(nres));
    endtask

    task automatic wait_done(output int dc);
        int i;
        dc = -1;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_o) begin
                dc = cyc_cnt;
                break;
            end
        end
        chk("done_seen", 512'(i < 200), 512'(1));
        tick();
        @(negedge clk);
        chk("idle_busy", 512'(busy_o), 512'(0));
        chk("idle_done", 512'(done_o), 512'(0));
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int fc, dc, xacc;
        rst = 1'b1; start_i = 1'b0; base_addr_i = '0; len_i = '0;
        result_valid_i = 1'b0; result_data_i = '0; ack_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", 512'({req_o, busy_o, done_o, result_ready_o, wlast_o}), 512'(0));
        chk("rst_addr", 512'(addr_o), 512'(0));
        chk("rst_wdata", wdata_o, 512'(0));
        tick();
        rst = 1'b0;
        tick();

        // 1: basic two-beat command, ack tied high
        ack_i = 1'b1;
        do_start(16'h0100, 8'd2);
        feed(16'h0100, 2, 8, 32'h100, fc);
        chk("t1_ready_cycles", 512'(fc), 512'(8));
        wait_done(dc);
        chk("t1_done_timing", 512'(dc), 512'(last_ack_cyc + 1));
        chk("t1_beats", 512'(seen_q.size()), 512'(2));
        chk("t1_addr1", 512'(seen_q[1]), 512'h0101);
        seen_q.delete();

        // 2: backpressure, buffer fills
        ack_i = 1'b0;
        do_start(16'h0200, 8'd8);
        fork
            feed(16'h0200, 8, 32, 32'h200, fc);
            begin
                repeat (30) @(negedge clk);
                chk("t2_accepts_stalled", 512'(g_acc), 512'(19));
                chk("t2_ready_low", 512'(result_ready_o), 512'(0));
                chk("t2_req_held", 512'(req_o), 512'(1));
                tick();
                ack_i = 1'b1;
            end
        join
        wait_done(dc);
        chk("t2_beats", 512'(seen_q.size()), 512'(8));
        seen_q.delete();

        // 3: zero-length command
        result_valid_i = 1'b1; result_data_i = mk(32'h300);
        start_i = 1'b1; base_addr_i = 16'h0300; len_i = 8'd0;
        @(negedge clk);
        chk("t3_done_early", 512'(done_o), 512'(0));
        tick();
        start_i = 1'b0;
        @(negedge clk);
        chk("t3_done", 512'(done_o), 512'(1));
        chk("t3_ready", 512'(result_ready_o), 512'(0));
        chk("t3_req", 512'(req_o), 512'(0));
        tick();
        @(negedge clk);
        chk("t3_done_pulse", 512'({done_o, busy_o, result_ready_o, req_o}), 512'(0));
        tick();
        result_valid_i = 1'b0;

        // 4: address wrap
        do_start(16'hFFFF, 8'd2);
        feed(16'hFFFF, 2, 8, 32'h400, fc);
        wait_done(dc);
        chk("t4_beats", 512'(seen_q.size()), 512'(2));
        chk("t4_addr0", 512'(seen_q[0]), 512'hFFFF);
        chk("t4_addr1", 512'(seen_q[1]), 512'h0000);
        seen_q.delete();

        // 5: mid-command start ignored, results capped at len*R
        ack_i = 1'b0;
        do_start(16'h0500, 8'd1);
        fork
            feed(16'h0500, 1, 4, 32'h500, fc);
            begin
                tick(); tick();
                start_i = 1'b1; base_addr_i = 16'h0600; len_i = 8'd5;
                tick();
                start_i = 1'b0;
            end
        join
        result_valid_i = 1'b1;
        xacc = 0;
        repeat (10) begin
            @(negedge clk);
            if (result_ready_o) xacc++;
            tick();
        end
        chk("t5_extra_accepts", 512'(xacc), 512'(0));
        chk("t5_busy", 512'(busy_o), 512'(1));
        result_valid_i = 1'b0;
        ack_i = 1'b1;
        wait_done(dc);
        chk("t5_beats", 512'(seen_q.size()), 512'(1));
        chk("t5_addr", 512'(seen_q[0]), 512'h0500);
        seen_q.delete();

        // 6: reset with two words buffered, then a fresh command
        ack_i = 1'b0;
        do_start(16'h0700, 8'd4);
        feed(16'h0700, 4, 8, 32'h700, fc);
        @(negedge clk);
        chk("t6_req_pending", 512'(req_o), 512'(1));
        tick();
        rst = 1'b1;
        sb_q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_ctrl", 512'({req_o, busy_o, done_o, result_ready_o, wlast_o}), 512'(0));
        chk("t6_rst_addr", 512'(addr_o), 512'(0));
        chk("t6_rst_wdata", wdata_o, 512'(0));
        tick();
        ack_i = 1'b1;
        seen_q.delete();
        do_start(16'h0800, 8'd1);
        feed(16'h0800, 1, 4, 32'h800, fc);
        wait_done(dc);
        chk("t6_beats", 512'(seen_q.size()), 512'(1));
        chk("t6_addr", 512'(seen_q[0]), 512'h0800);

        chk("sb_drained", 512'(sb_q.size()), 512'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
